// File: rtl/tx_bit_sequencer.sv
`timescale 1ns/1ps
// UART-style transmit bit sequencer: frames a word as start/data/parity/stop bits,
// pacing each bit from an external baud divider that it enables for the frame.
module tx_bit_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 baud_pulse,
    output logic                 div_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD_PAR   = (PARITY == 2);

    state_t               state;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_bit;
    logic [2:0]           bit_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            data_sr   <= '0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            ready_out <= 1'b1;
            div_en    <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The cycle carrying done is not an accept cycle; the next word waits one more cycle.
                    if (valid_in && ready_out && !done) begin
                        data_sr   <= data_in;
                        par_bit   <= (^data_in) ^ ODD_PAR;
                        bit_cnt   <= '0;
                        ready_out <= 1'b0;
                        busy      <= 1'b1;
                        div_en    <= 1'b1;
                        state     <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (baud_pulse) begin
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_pulse) begin
                        tx      <= data_sr[0];
                        data_sr <= data_sr >> 1;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_pulse) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx      <= data_sr[0];
                            data_sr <= data_sr >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_pulse) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_pulse) begin
                        if (bit_cnt == LAST_STOP) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            div_en    <= 1'b0;
                            ready_out <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_bit_sequencer.md
TX_BIT_SEQUENCER -- requirements
Module: tx_bit_sequencer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-002 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, DATA_BITS bits: word to send, sampled on accept.
REQ-007 SHALL have port valid_in, input, 1 bit: a word is offered on data_in.
REQ-008 SHALL have port ready_out, output, 1 bit: the block can accept a word.
REQ-009 SHALL have port baud_pulse, input, 1 bit: one-cycle bit-period pulse from the external baud divider.
REQ-010 SHALL have port div_en, output, 1 bit: enable for the external baud divider (drives its clk_en).
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a frame ends.

Function
REQ-014 SHALL register every output; no combinational path from input to output.
REQ-015 SHALL implement the states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-016 IDLE SHALL hold ready_out=1, div_en=0, tx=1 and busy=0.
REQ-017 SHALL accept a word when valid_in=1 and ready_out=1 in IDLE: latch data_in, clear ready_out, set busy=1 and div_en=1 on the next cycle, and enter SYNC.
REQ-018 SHALL ignore valid_in whenever ready_out=0, with no latch and no state change.
REQ-019 SYNC SHALL hold tx=1 until the first baud_pulse; that pulse is the divider phase-alignment pulse issued right after enable.
REQ-020 SHALL, on that first pulse, drive tx=0 on the next cycle and enter START.
REQ-021 SHALL, on every baud_pulse in START, DATA, PARITY or STOP, move to the next bit, with tx updating on the cycle after the pulse.
REQ-022 SHALL send data bits LSB first; a 3-bit bit counter counts 0..DATA_BITS-1 and leaves DATA when the count is DATA_BITS-1 and baud_pulse=1.
REQ-023 SHALL enter PARITY after DATA only when PARITY is not 0.
REQ-024 SHALL send a parity bit equal to the XOR of the latched data bits when PARITY=1, or its inverse when PARITY=2.
REQ-025 SHALL hold tx=1 in STOP for STOP_BITS baud periods.
REQ-026 SHALL, on the baud_pulse that ends STOP: pulse done for 1 cycle, clear busy, clear div_en, set ready_out=1, and return to IDLE, all on the same cycle.
REQ-027 SHALL NOT accept a new word on the same cycle done is asserted; the earliest accept is one cycle later, and SYNC re-aligns the divider.
REQ-028 SHALL ignore baud_pulse in IDLE.
REQ-029 SHALL keep div_en=1 continuously from SYNC through STOP, so the divider is never re-phased mid-frame.
REQ-030 SHALL give a frame length of 1 + DATA_BITS + (PARITY≠0) + STOP_BITS baud periods, measured from the first tx=0 cycle.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-frame, immediately set the state to IDLE, tx=1, div_en=0, busy=0, done=0, ready_out=1, and clear the bit counter and data register.
REQ-032 SHALL, on rst_n release, keep reset values until the first rising edge; a frame interrupted by reset is abandoned and never resumed.

Verification
REQ-033 Defaults, 0x55 offered, baud_pulse every 4 cycles -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, done one cycle after the final pulse.
REQ-034 PARITY=1, data 0x07 -> parity bit 1; PARITY=2, data 0x07 -> parity bit 0; frame is 11 periods.
REQ-035 valid_in held high for 3 consecutive frames with words 0xA0, 0x0F, 0xFF -> all three are sent in order, and ready_out is low between each accept and its done.
REQ-036 rst_n pulled low during data bit 4 of 0xC3 -> tx=1 and div_en=0 at once, ready_out=1, and no done pulse.
REQ-037 baud_pulse asserted while IDLE -> tx stays 1 and no state change; STOP_BITS=2, DATA_BITS=5 -> frame is 8 periods.
